dom_and_pipe: RTL and testbench
===============================

// Module: dom_and_pipe
// PURPOSE
//  Masked AND of two secrets a, b, each split into N=D+1 Boolean shares; produces N output shares of a&b.
//  Uses Domain-Oriented Masking (DOM), generalised to order D and W bit-sliced lanes.
//  Adds valid/ready flow control so it can sit inside stalling datapaths (S-box cores, masked adders).
// PARAMETERS
//  D  4  masking order; N=D+1 shares
//  W  1  bit-sliced lanes processed in parallel
//  R  D*(D+1)/2  fresh random bits per lane per transaction (derived, not overridable)
// PORTS
//  clock_0      in   1    clock, rising edge
//  reset_0      in   1    synchronous, active-high reset
//  io_i0        in   N*W  shares of a; share s at [s*W +: W]
//  io_i1        in   N*W  shares of b; same packing as io_i0
//  p_rand       in   R*W  fresh randomness; pair index k at [k*W +: W]
//  io_in_valid  in   1    input transaction present
//  io_in_ready  out  1    block accepts input this cycle
//  io_o0        out  N*W  shares of a&b; same packing as io_i0
//  io_out_valid out  1    io_o0 holds a valid result
//  io_out_ready in   1    downstream accepts io_o0
// BEHAVIOUR
//  Pair index: k enumerates pairs (i,j), i<j, in lexicographic order: (0,1)=0, (0,2)=1, ..., (D-1,D)=R-1.
//  Stage 1 (resharing regs) loads on in-fire = io_in_valid & io_in_ready:
//    - inner[i]   <= a_i & b_i
//    - cross[i][j] <= (a_i & b_j) ^ r_k, for every i != j
//    - r_k is shared by (i,j) and (j,i)
//  Compression: share i = inner[i] ^ XOR over j!=i of cross[i][j]; computed from stage-1 regs only.
//  Security:
//    - Every cross term is registered before any XOR across domains.
//    - No input signal feeds compression combinationally.
//  p_rand is sampled only on in-fire; ignored otherwise.
//  Flow control:
//    - s1_valid set on in-fire.
//    - s1_valid cleared when stage 1 is consumed and no new in-fire occurs.
//    - Registers hold their value while stalled; no re-sampling, no randomness reuse across transactions.
//  Simultaneous in-fire and stage-1 consume: new data loads; no bubble, full throughput of 1 txn/cycle.
//  Reset (any cycle, including mid-flight):
//    - all valid flags <= 0; all share regs <= 0; in-flight data is dropped.
//    - io_out_valid=0 and io_o0=0 in the cycle after reset_0 is sampled high.
//  io_in_ready is combinational from internal valids and io_out_ready; never from io_in_valid.
//  io_o0 stays stable while io_out_valid=1 and io_out_ready=0.
// CONFIGURATION
//  DOM_AND_PIPE_OUT_REG_EN defined (default in netlists):
//    - compressed shares are registered in a stage-2 out reg, loaded when stage 1 is valid and stage 2 is free or consumed.
//    - latency 2 cycles, in-fire to io_out_valid.
//    - io_out_valid = s2_valid.
//    - io_in_ready = !s1_valid | (!s2_valid | io_out_ready).
//  DOM_AND_PIPE_OUT_REG_EN undefined:
//    - io_o0 = combinational compression of stage 1; io_out_valid = s1_valid.
//    - latency 1 cycle.
//    - io_in_ready = !s1_valid | io_out_ready.
//    - caller must register io_o0 before any further nonlinear gate.
// TESTING
//  (D=4, W=1, macro defined unless stated)
//  T1 reset: hold reset_0=1 for 2 cycles, in_valid=1 -> out_valid=0, io_o0=0, no txn accepted.
//  T2 single txn: a shares=10000, b shares=10000, p_rand=0x001 (r_(0,1)=1)
//     -> after 2 cycles io_o0 shares=(0,1,0,0,0); XOR of shares = 1.
//  T3 random: 10k txns, random shares and p_rand, out_ready=1 -> unshared output == a&b every txn.
//     Also: one result per cycle after 2-cycle fill.
//  T4 backpressure: out_ready=0, push 3 txns.
//     -> 2 accepted, then in_ready=0; io_o0 stable.
//     -> release out_ready: results drain in order, no loss or duplicate.
//  T5 reset mid-flight: reset_0=1 one cycle with 2 txns in flight -> both dropped.
//     -> next txn's result is first out, after exactly 2 cycles.
//  T6 macro undefined: T2 stimulus -> same shares after 1 cycle.
//     T4 stimulus -> 1 accepted before in_ready=0.

Source files
------------

// File: rtl/dom_and_pipe.sv
// Order-D domain-oriented masked AND over W bit-sliced lanes, with valid/ready flow control.
// Define DOM_AND_PIPE_OUT_REG_EN to register the compressed shares (2-cycle latency instead of 1).
module dom_and_pipe #(
  parameter int D = 4,
  parameter int W = 1,
  localparam int N = D + 1,
  localparam int R = D * (D + 1) / 2
) (
  input  logic           clock_0,
  input  logic           reset_0,
  input  logic [N*W-1:0] io_i0,
  input  logic [N*W-1:0] io_i1,
  input  logic [R*W-1:0] p_rand,
  input  logic           io_in_valid,
  output logic           io_in_ready,
  output logic [N*W-1:0] io_o0,
  output logic           io_out_valid,
  input  logic           io_out_ready
);

  // Lexicographic index of the unordered pair {i,j}, i != j.
  function automatic int pair_idx(input int i, input int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * D - (lo * (lo - 1)) / 2 + (hi - lo - 1);
  endfunction

  logic           r_s1_valid;
  logic [W-1:0]   r_inner [N];
  logic [W-1:0]   r_cross [N][N];
  logic [N*W-1:0] w_comp;
  logic [W-1:0]   w_acc;
  logic           w_in_fire;
  logic           w_s1_consume;

  assign w_in_fire = io_in_valid & io_in_ready;

  // Cross-domain products are registered with their fresh mask before any cross-domain XOR.
  always_ff @(posedge clock_0) begin
    if (reset_0) begin
      r_s1_valid <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_inner[i] <= '0;
        for (int j = 0; j < N; j++) r_cross[i][j] <= '0;
      end
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      for (int i = 0; i < N; i++) begin
        r_inner[i] <= io_i0[i*W +: W] & io_i1[i*W +: W];
        for (int j = 0; j < N; j++) begin
          if (i != j)
            r_cross[i][j] <= (io_i0[i*W +: W] & io_i1[j*W +: W]) ^ p_rand[pair_idx(i, j)*W +: W];
          else
            r_cross[i][j] <= '0;
        end
      end
    end else if (w_s1_consume) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_comb begin
    w_comp = '0;
    w_acc  = '0;
    for (int i = 0; i < N; i++) begin
      w_acc = r_inner[i];
      for (int j = 0; j < N; j++) begin
        if (j != i) w_acc = w_acc ^ r_cross[i][j];
      end
      w_comp[i*W +: W] = w_acc;
    end
  end

`ifdef DOM_AND_PIPE_OUT_REG_EN
  logic           r_s2_valid;
  logic [N*W-1:0] r_out;
  logic           w_s2_free;

  assign w_s2_free    = ~r_s2_valid | io_out_ready;
  assign w_s1_consume = r_s1_valid & w_s2_free;
  assign io_in_ready  = ~r_s1_valid | w_s2_free;
  assign io_out_valid = r_s2_valid;
  assign io_o0        = r_out;

  always_ff @(posedge clock_0) begin
    if (reset_0) begin
      r_s2_valid <= 1'b0;
      r_out      <= '0;
    end else if (w_s1_consume) begin
      r_s2_valid <= 1'b1;
      r_out      <= w_comp;
    end else if (io_out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end
`else
  // Compression is combinational here; the consumer must register io_o0 before further nonlinear logic.
  assign w_s1_consume = r_s1_valid & io_out_ready;
  assign io_in_ready  = ~r_s1_valid | io_out_ready;
  assign io_out_valid = r_s1_valid;
  assign io_o0        = w_comp;
`endif

endmodule

// File: tb/tb_dom_and_pipe.sv
// Randomized bench for dom_and_pipe with a queue scoreboard and a share-level DOM reference.
// Adapts latency and stall capacity to whether DOM_AND_PIPE_OUT_REG_EN is defined.
module tb_dom_and_pipe;
  localparam int D = 4;
  localparam int W = 1;
  localparam int N = D + 1;
  localparam int R = D * (D + 1) / 2;
`ifdef DOM_AND_PIPE_OUT_REG_EN
  localparam int LAT = 2;
  localparam int CAP = 2;
`else
  localparam int LAT = 1;
  localparam int CAP = 1;
`endif

  logic           clock_0 = 1'b0;
  logic           reset_0 = 1'b1;
  logic [N*W-1:0] io_i0 = '0;
  logic [N*W-1:0] io_i1 = '0;
  logic [R*W-1:0] p_rand = '0;
  logic           io_in_valid = 1'b0;
  logic           io_in_ready;
  logic [N*W-1:0] io_o0;
  logic           io_out_valid;
  logic           io_out_ready = 1'b0;

  dom_and_pipe #(.D(D), .W(W)) dut (
    .clock_0(clock_0), .reset_0(reset_0), .io_i0(io_i0), .io_i1(io_i1), .p_rand(p_rand),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_o0(io_o0),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready)
  );

  always #5 clock_0 = ~clock_0;

  int cyc = 0;
  always @(posedge clock_0) cyc <= cyc + 1;

  typedef struct {
    logic [N*W-1:0] exp;
    int             t_in;
  } txn_t;
  txn_t q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int k_of[N][N];

  logic           s_in_ready;
  logic           s_out_valid;
  logic [N*W-1:0] s_o0;
  logic           s_fire_out;
  int             s_t;

  // Pair table built by counting pairs in order, independent of any closed form.
  task automatic init_pairs();
    int k;
    k = 0;
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++) begin
        k_of[i][j] = k;
        k_of[j][i] = k;
        k++;
      end
  endtask

  function automatic logic [N*W-1:0] dom_ref(input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                                             input logic [R*W-1:0] r);
    logic [N*W-1:0] o;
    logic s;
    o = '0;
    for (int l = 0; l < W; l++)
      for (int i = 0; i < N; i++) begin
        s = a[i*W+l] & b[i*W+l];
        for (int j = 0; j < N; j++)
          if (j != i) s = s ^ (a[i*W+l] & b[j*W+l]) ^ r[k_of[i][j]*W+l];
        o[i*W+l] = s;
      end
    return o;
  endfunction

  function automatic logic [W-1:0] unshare(input logic [N*W-1:0] v);
    logic [W-1:0] x;
    x = '0;
    for (int i = 0; i < N; i++) x = x ^ v[i*W +: W];
    return x;
  endfunction

  function automatic logic [N*W-1:0] rnd_sh();
    return (N*W)'($urandom());
  endfunction

  function automatic logic [R*W-1:0] rnd_r();
    return (R*W)'($urandom());
  endfunction

  // Drive one cycle's inputs, sample outputs, keep the model queue in step; no checking here.
  task automatic step(input logic rst, input logic iv, input logic [N*W-1:0] a,
                      input logic [N*W-1:0] b, input logic [R*W-1:0] r, input logic ordy);
    txn_t t;
    @(negedge clock_0);
    reset_0 = rst; io_in_valid = iv; io_i0 = a; io_i1 = b; p_rand = r; io_out_ready = ordy;
    #1;
    s_in_ready  = io_in_ready;
    s_out_valid = io_out_valid;
    s_o0        = io_o0;
    s_t         = cyc;
    s_fire_out  = io_out_valid && ordy && !rst;
    if (rst) q.delete();
    else if (iv && io_in_ready) begin
      t.exp  = dom_ref(a, b, r);
      t.t_in = cyc;
      q.push_back(t);
    end
    @(posedge clock_0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, rnd_sh(), rnd_sh(), rnd_r(), 1'b1);
    step(1'b1, 1'b1, rnd_sh(), rnd_sh(), rnd_r(), 1'b1);
    n_tests++;
    if (s_out_valid !== 1'b0 || s_o0 !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: out_valid=%b o0=%h, required 0 and 0", s_out_valid, s_o0);
    end
    for (int c = 0; c < LAT + 1; c++) begin
      step(1'b0, 1'b0, '0, '0, '0, 1'b1);
      n_tests++;
      if (s_out_valid !== 1'b0 || s_o0 !== '0) begin
        n_fail++;
        $display("FAIL reset_no_accept: cycle %0d out_valid=%b o0=%h, required 0 and 0", c, s_out_valid, s_o0);
      end
    end
  endtask

  task automatic test_single();
    int  t0;
    bit  seen;
    seen = 0;
    step(1'b0, 1'b1, 5'b00001, 5'b00001, 10'h001, 1'b1);
    t0 = s_t;
    for (int c = 0; c < 10 && !seen; c++) begin
      step(1'b0, 1'b0, '0, '0, '0, 1'b1);
      if (s_out_valid) begin
        seen = 1;
        if (s_fire_out && q.size() > 0) void'(q.pop_front());
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL single_timeout: out_valid never rose, required within 10 cycles");
    end else begin
      n_tests++;
      if (s_t - t0 != LAT) begin
        n_fail++;
        $display("FAIL single_latency: %0d cycles, required %0d", s_t - t0, LAT);
      end
      n_tests++;
      if (s_o0 !== 5'b00010) begin
        n_fail++;
        $display("FAIL single_shares: o0=%b, required 00010", s_o0);
      end
      n_tests++;
      if (unshare(s_o0) !== 1'b1) begin
        n_fail++;
        $display("FAIL single_unshared: %b, required 1", unshare(s_o0));
      end
    end
  endtask

  task automatic test_random();
    txn_t e;
    logic [N*W-1:0] a, b;
    logic [R*W-1:0] r;
    for (int n = 0; n < 10000 + LAT + 2; n++) begin
      a = rnd_sh(); b = rnd_sh(); r = rnd_r();
      step(1'b0, n < 10000, a, b, r, 1'b1);
      if (n < 10000) begin
        n_tests++;
        if (s_in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL random_in_ready: txn %0d in_ready=%b, required 1", n, s_in_ready);
        end
        if (q.size() > 0 && q[q.size()-1].t_in == s_t) begin
          n_tests++;
          if (q[q.size()-1].exp !== dom_ref(a, b, r) || unshare(dom_ref(a, b, r)) !== (unshare(a) & unshare(b))) begin
            n_fail++;
            $display("FAIL random_model: model disagrees with a&b for txn %0d", n);
          end
        end
      end
      if (s_fire_out) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL random_extra: unexpected output %h, required none", s_o0);
        end else begin
          e = q.pop_front();
          if (s_o0 !== e.exp || s_t - e.t_in != LAT) begin
            n_fail++;
            $display("FAIL random_result: o0=%h lat=%0d, required o0=%h lat=%0d", s_o0, s_t - e.t_in, e.exp, LAT);
          end
        end
      end
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL random_lost: %0d results missing, required 0", q.size());
    end
  endtask

  task automatic test_backpressure();
    txn_t e;
    logic [N*W-1:0] a, b, hold;
    logic [R*W-1:0] r;
    int acc, drained;
    bit have_hold;
    acc = 0; drained = 0; have_hold = 0; hold = '0;
    a = rnd_sh(); b = rnd_sh(); r = rnd_r();
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b1, a, b, r, 1'b0);
      if (s_in_ready) begin
        acc++;
        a = rnd_sh(); b = rnd_sh(); r = rnd_r();
      end
      if (s_out_valid) begin
        if (have_hold) begin
          n_tests++;
          if (s_o0 !== hold) begin
            n_fail++;
            $display("FAIL bp_stable: o0=%h, required %h", s_o0, hold);
          end
        end
        hold = s_o0; have_hold = 1;
      end
    end
    n_tests++;
    if (acc != CAP) begin
      n_fail++;
      $display("FAIL bp_accepted: %0d accepted, required %0d", acc, CAP);
    end
    n_tests++;
    if (s_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_in_ready: in_ready=%b, required 0", s_in_ready);
    end
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b0, '0, '0, '0, 1'b1);
      if (s_fire_out) begin
        drained++;
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_duplicate: extra output %h, required none", s_o0);
        end else begin
          e = q.pop_front();
          if (s_o0 !== e.exp) begin
            n_fail++;
            $display("FAIL bp_order: o0=%h, required %h", s_o0, e.exp);
          end
        end
      end
    end
    n_tests++;
    if (drained != CAP || q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain: drained %0d left %0d, required %0d and 0", drained, q.size(), CAP);
    end
  endtask

  task automatic test_reset_midflight();
    txn_t e;
    int t0;
    bit seen;
    seen = 0;
    for (int c = 0; c < 3; c++) step(1'b0, 1'b1, rnd_sh(), rnd_sh(), rnd_r(), 1'b0);
    n_tests++;
    if (q.size() != CAP) begin
      n_fail++;
      $display("FAIL mid_inflight: %0d in flight, required %0d", q.size(), CAP);
    end
    step(1'b1, 1'b0, '0, '0, '0, 1'b0);
    step(1'b0, 1'b1, rnd_sh(), rnd_sh(), rnd_r(), 1'b1);
    t0 = s_t;
    n_tests++;
    if (s_out_valid !== 1'b0 || s_o0 !== '0) begin
      n_fail++;
      $display("FAIL mid_after_reset: out_valid=%b o0=%h, required 0 and 0", s_out_valid, s_o0);
    end
    for (int c = 0; c < 10 && !seen; c++) begin
      step(1'b0, 1'b0, '0, '0, '0, 1'b1);
      if (s_fire_out) begin
        seen = 1;
        n_tests++;
        e = q.pop_front();
        if (s_o0 !== e.exp || s_t - t0 != LAT) begin
          n_fail++;
          $display("FAIL mid_first: o0=%h lat=%0d, required o0=%h lat=%0d", s_o0, s_t - t0, e.exp, LAT);
        end
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL mid_timeout: no result within 10 cycles, required one");
    end
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, '0, '0, '0, 1'b1);
      n_tests++;
      if (s_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_dropped: stale output %h, required none", s_o0);
      end
    end
  endtask

  task automatic test_random_stall();
    txn_t e;
    logic prev_v, prev_r, iv, ordy;
    logic [N*W-1:0] prev_o;
    prev_v = 0; prev_r = 1; prev_o = '0;
    for (int n = 0; n < 3020; n++) begin
      iv   = (n < 3000) ? 1'($urandom_range(0, 1)) : 1'b0;
      ordy = (n < 3000) ? ($urandom_range(0, 3) != 0) : 1'b1;
      step(1'b0, iv, rnd_sh(), rnd_sh(), rnd_r(), ordy);
      if (prev_v && !prev_r) begin
        n_tests++;
        if (s_out_valid !== 1'b1 || s_o0 !== prev_o) begin
          n_fail++;
          $display("FAIL stall_hold: out_valid=%b o0=%h, required 1 and %h", s_out_valid, s_o0, prev_o);
        end
      end
      if (s_fire_out) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL stall_extra: output %h, required none", s_o0);
        end else begin
          e = q.pop_front();
          if (s_o0 !== e.exp) begin
            n_fail++;
            $display("FAIL stall_result: o0=%h, required %h", s_o0, e.exp);
          end
        end
      end
      prev_v = s_out_valid; prev_r = ordy; prev_o = s_o0;
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_lost: %0d results missing, required 0", q.size());
    end
  endtask

  initial begin
    init_pairs();
    test_reset();
    test_single();
    test_random();
    test_backpressure();
    test_reset_midflight();
    test_random_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
